mesh_mix_sequencer: RTL and testbench

Sequences fluid injections into the two-input diffusion-mixer mesh. Requesters compete for mesh inputs through round-robin arbitration. The block then drives a fixed fill → mix → drain cycle on the inlet valves, the pump and the outlet valves. Only one injection is in flight at a time. The block sits between the host protocol controller and the mesh's valve and pump actuators.

---
 rtl/mesh_mix_sequencer.sv | 172 +++++++++++++++++
 tb/tb_mesh_mix_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_mix_sequencer.sv
// mesh_mix_sequencer
//
// Sequences fluid injections into the two-input diffusion-mixer mesh.
// Requesters compete for the mesh through a round-robin arbiter. The winner
// then gets a fixed fill -> mix -> drain cycle on the inlet valve, the pump
// and the outlet valves. Only one injection is in flight at a time.
//
// Ports
//   clk           single clock, rising edge
//   rst           asynchronous active-high reset; closes all actuators at once
//   req           level request per mesh input, held until granted
//   abort         cancel the current injection (honoured in FILL or MIX)
//   grant         one-hot, one-cycle pulse naming the accepted requester
//   inlet_valve   one-hot open command for the granted inlet (FILL only)
//   pump_en       pump drive (FILL and DRAIN)
//   outlet_valve  all bits open together during DRAIN
//   busy          high in every state except IDLE
//   done          one-cycle completion pulse
//   done_id       index of the completed or aborted requester, valid with done
//   aborted       qualifies done: the cycle was ended by abort
//
// Every output is registered. The output registers are loaded from the
// next-state decode, so each actuator changes on the same edge as the
// state transition that calls for it.
module mesh_mix_sequencer #(
  parameter int N_INPUTS     = 2,
  parameter int CNT_W        = 8,
  parameter int FILL_CYCLES  = 16,
  parameter int MIX_CYCLES   = 64,
  parameter int DRAIN_CYCLES = 16,
  localparam int ID_W = $clog2(N_INPUTS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_INPUTS-1:0] req,
  input  logic                abort,
  output logic [N_INPUTS-1:0] grant,
  output logic [N_INPUTS-1:0] inlet_valve,
  output logic                pump_en,
  output logic [N_INPUTS-1:0] outlet_valve,
  output logic                busy,
  output logic                done,
  output logic [ID_W-1:0]     done_id,
  output logic                aborted
);

  // Counters run from length-1 down to 0; the phase ends on the zero cycle.
  localparam logic [CNT_W-1:0] FILL_LOAD  = CNT_W'(FILL_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIX_LOAD   = CNT_W'(MIX_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [ID_W-1:0]  LAST_ID    = ID_W'(N_INPUTS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_MIX,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [ID_W-1:0]  ptr, ptr_n;
  logic [ID_W-1:0]  cur_id, cur_id_n;
  logic [ID_W-1:0]  sel_id;
  logic             aborted_n;

  function automatic logic [N_INPUTS-1:0] onehot(input logic [ID_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Round-robin pick: the first set request at or after the pointer,
  // wrapping. Scanning from the farthest offset down lets the nearest
  // requester overwrite the others, so no found-flag is needed.
  always_comb begin
    sel_id = ptr;
    for (int k = N_INPUTS - 1; k >= 0; k--) begin
      if (req[ID_W'((int'(ptr) + k) % N_INPUTS)]) begin
        sel_id = ID_W'((int'(ptr) + k) % N_INPUTS);
      end
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ptr_n     = ptr;
    cur_id_n  = cur_id;
    aborted_n = aborted;
    unique case (state)
      ST_IDLE: begin
        if (|req) begin
          state_n  = ST_FILL;
          cnt_n    = FILL_LOAD;
          cur_id_n = sel_id;
          ptr_n    = (sel_id == LAST_ID) ? '0 : sel_id + 1'b1;
        end
      end
      ST_FILL: begin
        // Abort wins over the natural end of the phase: a full drain always runs.
        if (abort) begin
          state_n   = ST_DRAIN;
          cnt_n     = DRAIN_LOAD;
          aborted_n = 1'b1;
        end else if (cnt == '0) begin
          state_n = ST_MIX;
          cnt_n   = MIX_LOAD;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      ST_MIX: begin
        if (abort || cnt == '0) begin
          state_n   = ST_DRAIN;
          cnt_n     = DRAIN_LOAD;
          aborted_n = aborted | abort;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cnt == '0) begin
          state_n = ST_DONE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      ST_DONE: begin
        state_n   = ST_IDLE;
        aborted_n = 1'b0;
      end
      default: begin
        state_n   = ST_IDLE;
        aborted_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      ptr          <= '0;
      cur_id       <= '0;
      grant        <= '0;
      inlet_valve  <= '0;
      pump_en      <= 1'b0;
      outlet_valve <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      done_id      <= '0;
      aborted      <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      ptr          <= ptr_n;
      cur_id       <= cur_id_n;
      grant        <= (state == ST_IDLE && |req) ? onehot(sel_id) : '0;
      inlet_valve  <= (state_n == ST_FILL) ? onehot(cur_id_n) : '0;
      pump_en      <= (state_n == ST_FILL) || (state_n == ST_DRAIN);
      outlet_valve <= (state_n == ST_DRAIN) ? '1 : '0;
      busy         <= (state_n != ST_IDLE);
      done         <= (state_n == ST_DONE);
      aborted      <= aborted_n;
      if (state_n == ST_DONE) begin
        done_id <= cur_id_n;
      end
    end
  end

endmodule

// File: tb/tb_mesh_mix_sequencer.sv
// tb_mesh_mix_sequencer
//
// Bench for mesh_mix_sequencer with N_INPUTS=2, FILL=4, MIX=8, DRAIN=3.
// A transaction-level reference model tracks each injection as a start cycle
// and a drain-start cycle and derives the phase of any cycle from those by
// arithmetic. Expected grant and done events are queued when the model
// decides them; a monitor on the falling edge pops and compares them and also
// compares the actuator outputs every cycle.
module tb_mesh_mix_sequencer;

  localparam int N = 2;
  localparam int F = 4;
  localparam int M = 8;
  localparam int D = 3;

  localparam int P_IDLE  = 0;
  localparam int P_FILL  = 1;
  localparam int P_MIX   = 2;
  localparam int P_DRAIN = 3;
  localparam int P_DONE  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic       abort = 1'b0;
  logic [1:0] grant;
  logic [1:0] inlet_valve;
  logic       pump_en;
  logic [1:0] outlet_valve;
  logic       busy;
  logic       done;
  logic       done_id;
  logic       aborted;

  mesh_mix_sequencer #(
    .N_INPUTS    (N),
    .CNT_W       (8),
    .FILL_CYCLES (F),
    .MIX_CYCLES  (M),
    .DRAIN_CYCLES(D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .abort       (abort),
    .grant       (grant),
    .inlet_valve (inlet_valve),
    .pump_en     (pump_en),
    .outlet_valve(outlet_valve),
    .busy        (busy),
    .done        (done),
    .done_id     (done_id),
    .aborted     (aborted)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int cyc;
    int id;
    bit ab;
  } ev_t;

  ev_t gq[$];
  ev_t dq[$];
  bit  m_act   = 1'b0;
  int  m_start = 0;
  int  m_drain = 0;
  int  m_id    = 0;
  int  m_ptr   = 0;
  bit  m_ab    = 1'b0;

  function automatic int phase_of(input int c);
    if (!m_act) return P_IDLE;
    if (c < m_drain) return ((c - m_start) < F) ? P_FILL : P_MIX;
    if (c < m_drain + D) return P_DRAIN;
    return P_DONE;
  endfunction

  task automatic model_reset();
    m_act = 1'b0;
    m_ptr = 0;
    m_ab  = 1'b0;
    gq.delete();
    dq.delete();
  endtask

  task automatic model_step(input int c, input logic [1:0] r, input logic a);
    int         ph;
    int         pick;
    int         idx;
    logic [1:0] rr;
    ph = phase_of(c);
    if (ph == P_IDLE) begin
      if (r != 2'b00) begin
        pick = -1;
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          rr  = r >> idx;
          if (pick < 0 && rr[0]) pick = idx;
        end
        m_act   = 1'b1;
        m_start = c + 1;
        m_drain = c + 1 + F + M;
        m_ab    = 1'b0;
        m_id    = pick;
        m_ptr   = (pick + 1) % N;
        gq.push_back('{cyc: c + 1, id: pick, ab: 1'b0});
      end
    end else if (ph == P_FILL || ph == P_MIX) begin
      if (a) begin
        m_drain = c + 1;
        m_ab    = 1'b1;
      end
    end else if (ph == P_DRAIN) begin
      if (c + 1 == m_drain + D) dq.push_back('{cyc: c + 1, id: m_id, ab: m_ab});
    end else begin
      m_act = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (rst) model_reset();
      else model_step(cyc, req, abort);
      cyc++;
    end
  end

  // ---------------- monitor ----------------
  logic [1:0] prev_grant = 2'b00;
  int  done_cnt = 0;
  int  last_grant_cyc = 0;
  int  last_done_cyc = 0;
  bit  last_done_ab = 1'b0;
  int  glog[$];
  int  gcyc[$];
  int  dlog[$];

  initial begin
    int  ph;
    ev_t e;
    forever begin
      @(negedge clk);
      ph = phase_of(cyc);
      chk("inlet_valve", int'(inlet_valve), (ph == P_FILL) ? (1 << m_id) : 0);
      chk("outlet_valve", int'(outlet_valve), (ph == P_DRAIN) ? 3 : 0);
      chk("pump_en", int'(pump_en), int'(ph == P_FILL || ph == P_DRAIN));
      chk("busy", int'(busy), int'(ph != P_IDLE));
      chk("done", int'(done), int'(ph == P_DONE));
      chk("valves_exclusive", int'(inlet_valve != 2'b00 && outlet_valve != 2'b00), 0);
      chk("inlet_onehot0", int'($onehot0(inlet_valve)), 1);
      chk("grant_pulse", int'(prev_grant != 2'b00 && grant != 2'b00), 0);
      if (grant != 2'b00) begin
        if (gq.size() == 0) begin
          chk("grant_unexpected", int'(grant), 0);
        end else begin
          e = gq.pop_front();
          chk("grant_id", int'(grant), 1 << e.id);
          chk("grant_cycle", cyc, e.cyc);
        end
        glog.push_back(int'(grant));
        gcyc.push_back(cyc);
        last_grant_cyc = cyc;
      end else if (gq.size() != 0 && gq[0].cyc <= cyc) begin
        e = gq.pop_front();
        chk("grant_missing", int'(grant), 1 << e.id);
      end
      if (done) begin
        if (dq.size() == 0) begin
          chk("done_unexpected", int'(done), 0);
        end else begin
          e = dq.pop_front();
          chk("done_id", int'(done_id), e.id);
          chk("done_aborted", int'(aborted), int'(e.ab));
          chk("done_cycle", cyc, e.cyc);
        end
        dlog.push_back(int'(done_id));
        done_cnt++;
        last_done_cyc = cyc;
        last_done_ab  = aborted;
      end else if (dq.size() != 0 && dq[0].cyc <= cyc) begin
        e = dq.pop_front();
        chk("done_missing", int'(done), 1);
      end
      prev_grant = grant;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("wait_idle_timeout", 1, 0);
  endtask

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("wait_done_timeout", 1, 0);
  endtask

  // k > 0: abort is high during the k-th cycle after the grant cycle.
  task automatic run_req(input logic [1:0] m, input int k, input bit ab_idle,
                         input int span, input bit ab);
    int d0;
    wait_idle();
    d0    = done_cnt;
    req   = m;
    abort = ab_idle;
    tick();
    req   = 2'b00;
    abort = 1'b0;
    if (k > 0) begin
      repeat (k) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end
    wait_done(d0);
    chk("span", last_done_cyc - last_grant_cyc, span);
    chk("span_aborted", int'(last_done_ab), int'(ab));
  endtask

  initial begin
    int base;
    int dbase;
    int n;
    int d0;

    rst = 1'b1;
    repeat (3) tick();
    chk("rst_grant", int'(grant), 0);
    chk("rst_inlet", int'(inlet_valve), 0);
    chk("rst_outlet", int'(outlet_valve), 0);
    chk("rst_pump", int'(pump_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_done_id", int'(done_id), 0);
    chk("rst_aborted", int'(aborted), 0);
    rst = 1'b0;
    tick();

    // Contention from a fresh pointer: grants 01, 10, 01 spaced 17 cycles.
    base  = glog.size();
    dbase = dlog.size();
    req   = 2'b11;
    n     = 0;
    while (glog.size() < base + 3 && n < 200) begin
      tick();
      n++;
    end
    req = 2'b00;
    if (glog.size() < base + 3) begin
      chk("contention_timeout", 1, 0);
    end else begin
      chk("contention_g0", glog[base], 1);
      chk("contention_g1", glog[base + 1], 2);
      chk("contention_g2", glog[base + 2], 1);
      chk("contention_gap0", gcyc[base + 1] - gcyc[base], 17);
      chk("contention_gap1", gcyc[base + 2] - gcyc[base + 1], 17);
    end
    wait_idle();
    if (dlog.size() < dbase + 3) begin
      chk("contention_done_count", dlog.size() - dbase, 3);
    end else begin
      chk("contention_d0", dlog[dbase], 0);
      chk("contention_d1", dlog[dbase + 1], 1);
      chk("contention_d2", dlog[dbase + 2], 0);
    end

    run_req(2'b01, 0, 1'b0, 15, 1'b0);   // single request
    run_req(2'b01, 6, 1'b0, 10, 1'b1);   // abort in MIX
    run_req(2'b10, 2, 1'b0, 6, 1'b1);    // abort in FILL
    run_req(2'b10, 13, 1'b0, 15, 1'b0);  // abort in DRAIN ignored
    run_req(2'b01, 0, 1'b1, 15, 1'b0);   // abort with req in IDLE ignored

    // Reset mid-FILL, then req=10 after release.
    wait_idle();
    req = 2'b01;
    tick();
    req = 2'b00;
    tick();
    d0  = done_cnt;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_mid_inlet", int'(inlet_valve), 0);
    chk("rst_mid_pump", int'(pump_en), 0);
    chk("rst_mid_busy", int'(busy), 0);
    tick();
    tick();
    rst = 1'b0;
    req = 2'b10;
    tick();
    chk("rst_release_grant", int'(grant), 2);
    chk("rst_no_done", done_cnt, d0);
    req = 2'b00;
    wait_idle();

    // Reset after granting input 0 must bring the pointer back to 0.
    req = 2'b01;
    tick();
    req = 2'b00;
    tick();
    rst = 1'b1;
    model_reset();
    tick();
    rst = 1'b0;
    req = 2'b11;
    tick();
    chk("rst_ptr_grant", int'(grant), 1);
    req = 2'b00;
    wait_idle();

    // Random request/abort traffic.
    for (int i = 0; i < 600; i++) begin
      tick();
      req   = 2'($urandom_range(0, 3));
      abort = ($urandom_range(0, 7) == 0);
    end
    req   = 2'b00;
    abort = 1'b0;
    tick();
    wait_idle();
    tick();
    chk("grant_queue_empty", gq.size(), 0);
    chk("done_queue_empty", dq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
